// File: rtl/sched_pkg.sv
// Shared types and default sizing for the child grant scheduler.
package sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Default number of children and grant index width.
    localparam int unsigned DEF_N_REQ = 5;
    localparam int unsigned DEF_ID_W  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_id+1, wrapping from N_REQ-1 back to 0.
module rr_pick
    import sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             found,
    output logic [ID_W-1:0]  win_id
);

    logic [ID_W-1:0] cand;

    // Walk candidates in rotated order; the first hit is the winner.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((32'(last_id) + i) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

endmodule

// File: rtl/child_grant_scheduler.sv
// Grants a single shared resource to one of N_REQ children in round-robin
// order. Optional forced revoke after MAX_HOLD grant cycles is enabled by
// defining SCHED_TIMEOUT_EN.
module child_grant_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned ID_W     = DEF_ID_W,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             revoke
);

    // Reject configurations the index or hold counter cannot represent.
    if ((1 << ID_W) < N_REQ) begin : g_bad_id_w
        $error("ID_W too narrow for N_REQ");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic             revoke_q, revoke_d;
    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic             held_req, held_done;
    logic             timeout;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id_q),
        .found   (pick_found),
        .win_id  (pick_id)
    );

    // Only the granted child's request and done bits matter.
    assign held_req  = req[grant_id_q];
    assign held_done = done[grant_id_q];

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CNT_W'(MAX_HOLD - 1));

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic; done/request loss takes precedence over timeout.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        revoke_d   = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = N_REQ'(1) << pick_id;
                    grant_id_d = pick_id;
                    state_d    = GRANT;
`ifdef SCHED_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            GRANT: begin
                if (held_done || !held_req) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end else if (timeout) begin
                    grant_d  = '0;
                    revoke_d = 1'b1;
                    state_d  = RELEASE;
                end else begin
`ifdef SCHED_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                last_id_d = grant_id_q;
                state_d   = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
            revoke_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            revoke_q   <= revoke_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);
    assign revoke   = revoke_q;

endmodule

// File: tb/tb_child_grant_scheduler.sv
// Directed self-checking bench for child_grant_scheduler. Expected grant
// indices are queued when requests are driven and popped when a grant shows.
// Timeout checks follow SCHED_TIMEOUT_EN.
module tb_child_grant_scheduler;
    import sched_pkg::*;

    localparam int unsigned N = 5;
    localparam int unsigned W = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [W-1:0] grant_id;
    logic         busy;
    logic         revoke;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    child_grant_scheduler #(
        .N_REQ    (N),
        .ID_W     (W),
        .MAX_HOLD (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .revoke   (revoke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant, then compare against the scoreboard head.
    task automatic wait_grant(input string tag, input int budget);
        int n;
        int exp;
        n = 0;
        while (grant == '0 && n < budget) begin
            step();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_id"}, 32'(grant_id), 32'(exp));
        check({tag, "_grant"}, 32'(grant), 32'(1) << exp);
    endtask

    // Invariants sampled mid-cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("onehot0", 32'($onehot0(grant)), 32'(1));
            check("busy_state", 32'(busy), 32'(dut.state_q != IDLE));
`ifndef SCHED_TIMEOUT_EN
            check("revoke_tied", 32'(revoke), 32'(0));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_revoke", 32'(revoke), 32'(0));
        check("rst_last_id", 32'(dut.last_id_q), 32'(N - 1));

        // All children requesting: 0,1,2,3,4,0 with a RELEASE gap each.
        @(negedge clk);
        rst_n = 1'b1;
        req   = 5'b11111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(4);
        exp_q.push_back(0);
        for (int k = 0; k < 6; k++) begin
            wait_grant($sformatf("rr%0d", k), 4);
            if (k < 5) done = N'(1) << grant_id;
            else req = '0;
            step();
            done = '0;
            check($sformatf("rr%0d_rel_grant", k), 32'(grant), 32'(0));
            check($sformatf("rr%0d_rel_busy", k), 32'(busy), 32'(1));
        end
        step();
        check("rr_idle_busy", 32'(busy), 32'(0));

        // Single request from child 3: grant exactly one edge later.
        req = 5'b01000;
        exp_q.push_back(3);
        step();
        wait_grant("lat3", 0);
        done = 5'b01000;
        step();
        done = '0;
        req  = '0;
        check("lat3_rel_grant", 32'(grant), 32'(0));
        step();
        check("lat3_idle_busy", 32'(busy), 32'(0));

        // Child 2 granted; a foreign done is ignored, dropping req releases.
        req = 5'b00100;
        exp_q.push_back(2);
        step();
        wait_grant("c2", 0);
        done = 5'b10000;
        step();
        step();
        done = '0;
        check("c2_foreign_done", 32'(grant), 32'(5'b00100));
        check("c2_foreign_busy", 32'(busy), 32'(1));
        req = '0;
        step();
        check("c2_drop_grant", 32'(grant), 32'(0));
        check("c2_drop_busy", 32'(busy), 32'(1));
        step();
        check("c2_idle_busy", 32'(busy), 32'(0));

        // Child 1 holds its request with no done.
        req = 5'b00010;
        exp_q.push_back(1);
        step();
        wait_grant("hold1", 0);
`ifdef SCHED_TIMEOUT_EN
        repeat (7) step();
        check("hold1_before_to", 32'(grant), 32'(5'b00010));
        check("hold1_no_revoke", 32'(revoke), 32'(0));
        step();
        check("hold1_to_grant", 32'(grant), 32'(0));
        check("hold1_to_revoke", 32'(revoke), 32'(1));
        req = '0;
        step();
        check("hold1_revoke_pulse", 32'(revoke), 32'(0));
        check("hold1_idle_busy", 32'(busy), 32'(0));
`else
        repeat (110) step();
        check("hold1_persist_grant", 32'(grant), 32'(5'b00010));
        check("hold1_persist_busy", 32'(busy), 32'(1));
        req = '0;
        step();
        check("hold1_rel_grant", 32'(grant), 32'(0));
        step();
        check("hold1_idle_busy", 32'(busy), 32'(0));
`endif

        // Reset asserted while child 4 is granted drops grant at once.
        req = 5'b10000;
        exp_q.push_back(4);
        step();
        wait_grant("c4", 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("c4_async_grant", 32'(grant), 32'(0));
        check("c4_async_busy", 32'(busy), 32'(0));
        req = 5'b10001;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(0);
        step();
        wait_grant("post_rst", 0);

        req = '0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/child_grant_scheduler.md
CHILD_GRANT_SCHEDULER -- requirements
Module: child_grant_scheduler

Interface
REQ-001 Parameter N_REQ, default 5, is the number of child instances that share the single downstream resource.
REQ-002 Parameter ID_W, default 3, is the width of the grant index; it SHALL satisfy 2**ID_W >= N_REQ.
REQ-003 Parameter MAX_HOLD, default 8, is the maximum number of cycles in GRANT before forced revoke (used only with the macro).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  N_REQ  per-child request; level, held until served.
REQ-007 done  input  N_REQ  per-child release strobe; only the bit of the granted child is honoured.
REQ-008 grant  output  N_REQ  one-hot grant; all zero when no child is granted.
REQ-009 grant_id  output  ID_W  index of the granted child; holds the last granted index when grant is zero.
REQ-010 busy  output  1  high while the FSM is in GRANT or RELEASE.
REQ-011 revoke  output  1  one-cycle pulse when a grant is forcibly ended by timeout.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-013 IDLE: if any req bit is high, select the winner, register grant/grant_id, and go to GRANT; else stay in IDLE.
REQ-014 Winner selection SHALL be round-robin: first set req bit searching upward from last_id+1, wrapping from N_REQ-1 to 0.
REQ-015 Latency: req rising in IDLE at edge t SHALL give grant visible after edge t+1.
REQ-016 GRANT: grant stays constant while req[grant_id]=1 and done[grant_id]=0.
REQ-017 GRANT exit: done[grant_id]=1 or req[grant_id]=0 -> RELEASE on the next edge; done bits of non-granted children are ignored.
REQ-018 RELEASE: lasts exactly one cycle with grant=0; last_id<=grant_id; next state IDLE.
REQ-019 Simultaneous requests SHALL be resolved only by the round-robin order; no child is granted twice while another child has been requesting continuously.
REQ-020 At most one grant bit SHALL be high in any cycle.
REQ-021 Request bits at index >= N_REQ do not exist; grant_id SHALL never exceed N_REQ-1.

Reset
REQ-022 While rst_n=0: state=IDLE, grant=0, grant_id=0, busy=0, revoke=0, last_id=N_REQ-1 (so child 0 wins first), hold counter=0.
REQ-023 Reset asserted mid-GRANT SHALL drop grant immediately (asynchronously); there is no RELEASE cycle.

Configuration
REQ-024 Macro SCHED_TIMEOUT_EN, when defined, adds a hold counter cleared on GRANT entry and incremented each GRANT cycle.
REQ-025 With SCHED_TIMEOUT_EN: when the counter reaches MAX_HOLD-1 without done, the next edge forces RELEASE and pulses revoke for one cycle; if done and timeout occur in the same cycle, done wins and revoke stays 0.
REQ-026 Without SCHED_TIMEOUT_EN: no counter logic exists, revoke is tied 0, and a grant lasts indefinitely.

Structure
REQ-027 Shared package sched_pkg SHALL hold the state enum (IDLE, GRANT, RELEASE) and the default N_REQ/ID_W constants.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_id; outputs found, win_id).

Verification
REQ-029 After reset, req=5'b11111 -> grants in order 0,1,2,3,4,0, each separated by a RELEASE cycle with grant=0.
REQ-030 Only req[3] high in IDLE at edge t -> grant=5'b01000 and grant_id=3 after edge t+1; done[3] pulsed -> grant=0 next cycle, then IDLE.
REQ-031 Child 2 granted, done[4] pulsed -> grant unchanged; req[2] dropped -> RELEASE next edge.
REQ-032 With SCHED_TIMEOUT_EN, MAX_HOLD=8, child 1 holds req with no done -> revoke pulse and grant=0 after 8 GRANT cycles; without the macro the grant persists for more than 100 cycles.
REQ-033 rst_n asserted while child 4 is granted -> grant=0 at once; after release of reset with req=5'b10001, child 0 is granted first.
REQ-034 Throughout all scenarios, assertions check that grant is one-hot or zero and that busy equals (state != IDLE).
